// File: rtl/sm_pkg.sv
// Shared definitions for the sign-magnitude datapath blocks: default widths,
// sign bit position, accumulator state encoding and the canonical zero.
package sm_pkg;

    localparam int SM_DATA_W = 12;
    localparam int SM_ACC_W  = 16;
    localparam int SIGN_POS  = SM_ACC_W - 1;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } sm_state_e;

    // +0; -0 is never produced by the datapath
    localparam logic [SM_ACC_W-1:0] SM_ZERO = '0;

endpackage

// File: rtl/sm_add_core.sv
// Combinational sign-magnitude adder: widens both operands to the result
// width, adds or subtracts magnitudes, saturates on overflow and never
// produces -0. A subtractor is obtained by flipping the sign bit of b.
module sm_add_core #(
    parameter int A_W = 16,
    parameter int B_W = 12,
    parameter int Y_W = 16
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [Y_W-1:0] y,
    output logic           sat
);

    localparam int M_W = Y_W - 1;

    logic [M_W-1:0] mag_a;
    logic [M_W-1:0] mag_b;
    logic [M_W-1:0] mag_y;
    logic           sgn_a;
    logic           sgn_b;
    logic           sgn_y;
    logic [M_W:0]   sum_w;

    // Widen, pick add vs subtract by sign, then saturate and normalise -0
    always_comb begin
        mag_a = M_W'(a[A_W-2:0]);
        mag_b = M_W'(b[B_W-2:0]);
        // a zero magnitude counts as positive, so -0 inputs behave as +0
        sgn_a = a[A_W-1] & (|mag_a);
        sgn_b = b[B_W-1] & (|mag_b);
        sum_w = {1'b0, mag_a} + {1'b0, mag_b};
        sat   = 1'b0;
        mag_y = '0;
        sgn_y = 1'b0;
        if (sgn_a == sgn_b) begin
            sgn_y = sgn_a;
            if (sum_w[M_W]) begin
                mag_y = '1;
                sat   = 1'b1;
            end else begin
                mag_y = sum_w[M_W-1:0];
            end
        end else if (mag_a >= mag_b) begin
            mag_y = mag_a - mag_b;
            sgn_y = sgn_a;
        end else begin
            mag_y = mag_b - mag_a;
            sgn_y = sgn_b;
        end
        // equal magnitudes of opposite sign must come out as +0
        sgn_y = sgn_y & (|mag_y);
        y     = {sgn_y, mag_y};
    end

endmodule

// File: rtl/sm_block_accumulator.sv
// Streaming sign-magnitude block accumulator: sums BLOCK_LEN accepted
// samples and presents the sum on a valid/ready output held until taken.
// Optional macro SM_ACC_SAT_FLAG_EN adds out_sat, flagging any saturating
// add within the block.
module sm_block_accumulator
    import sm_pkg::*;
#(
    parameter int DATA_W    = SM_DATA_W,
    parameter int ACC_W     = SM_ACC_W,
    parameter int BLOCK_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef SM_ACC_SAT_FLAG_EN
    ,
    output logic              out_sat
`endif
);

    localparam int              CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);
    localparam logic [ACC_W-1:0] ZERO = ACC_W'(SM_ZERO);

    sm_state_e        state_q,     state_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [ACC_W-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;

    logic [ACC_W-1:0] add_y;
    logic             add_sat;
    logic             beat;
    logic             last_beat;

    sm_add_core #(
        .A_W (ACC_W),
        .B_W (DATA_W),
        .Y_W (ACC_W)
    ) u_add (
        .a   (acc_q),
        .b   (in_data),
        .y   (add_y),
        .sat (add_sat)
    );

    // rst gates in_ready so nothing is taken during the reset cycle
    assign in_ready  = (state_q == ST_ACC) & ~clr & ~rst;
    assign beat      = in_valid & in_ready;
    assign last_beat = beat & (count_q == LAST);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    // Next-state: accumulate in ACC, wait for the handshake in HOLD; clr wins
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_ACC: begin
                if (last_beat) begin
                    out_data_d  = add_y;
                    out_valid_d = 1'b1;
                    acc_d       = ZERO;
                    count_d     = '0;
                    state_d     = ST_HOLD;
                end else if (beat) begin
                    acc_d   = add_y;
                    count_d = count_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
        // abort: partial sum and any pending output are dropped
        if (clr) begin
            acc_d       = ZERO;
            count_d     = '0;
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= ZERO;
            count_q     <= '0;
            out_data_q  <= ZERO;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SM_ACC_SAT_FLAG_EN
    logic sat_blk_q, sat_blk_d;
    logic out_sat_q, out_sat_d;

    assign out_sat = out_sat_q;

    // Collect saturation across the block, publish it with the sum
    always_comb begin
        sat_blk_d = sat_blk_q;
        out_sat_d = out_sat_q;
        if (last_beat) begin
            out_sat_d = sat_blk_q | add_sat;
            sat_blk_d = 1'b0;
        end else if (beat) begin
            sat_blk_d = sat_blk_q | add_sat;
        end
        if (clr) begin
            sat_blk_d = 1'b0;
            out_sat_d = 1'b0;
        end
    end

    // Saturation flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_blk_q <= 1'b0;
            out_sat_q <= 1'b0;
        end else begin
            sat_blk_q <= sat_blk_d;
            out_sat_q <= out_sat_d;
        end
    end
`else
    logic sat_unused;
    assign sat_unused = add_sat;
`endif

endmodule

// File: tb/tb_sm_block_accumulator.sv
// Scoreboard bench: two accumulators (BLOCK_LEN 4 and 20) share one input
// stream; an integer reference model predicts each block sum into a queue
// and a monitor compares whatever the DUT presents.
module tb_sm_block_accumulator;

    typedef struct packed {
        logic [15:0] data;
        logic        sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [11:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic [1:0]  in_ready_w;
    logic [1:0]  out_valid_w;
    logic [15:0] out_data_w [2];
    logic [1:0]  out_sat_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: signed integer running sum clamped to the 15-bit magnitude
    function automatic int ref_add(input int acc, input logic [11:0] d);
        int mag = int'(d[10:0]);
        int r   = d[11] ? acc - mag : acc + mag;
        if (r > 32767)  r = 32767;
        if (r < -32767) r = -32767;
        return r;
    endfunction

    function automatic bit ref_sat(input int acc, input logic [11:0] d);
        int mag = int'(d[10:0]);
        int r   = d[11] ? acc - mag : acc + mag;
        return (r > 32767) || (r < -32767);
    endfunction

    function automatic logic [15:0] enc(input int v);
        return (v < 0) ? {1'b1, 15'(-v)} : {1'b0, 15'(v)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_inst
        localparam int BL = (g == 0) ? 4 : 20;

        exp_t q[$];
        int   m_acc  = 0;
        int   m_cnt  = 0;
        bit   m_hold = 1'b0;
        bit   m_sat  = 1'b0;

        sm_block_accumulator #(
            .DATA_W    (12),
            .ACC_W     (16),
            .BLOCK_LEN (BL)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .in_data   (in_data),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .out_data  (out_data_w[g]),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready)
`ifdef SM_ACC_SAT_FLAG_EN
            ,
            .out_sat   (out_sat_w[g])
`endif
        );

`ifndef SM_ACC_SAT_FLAG_EN
        assign out_sat_w[g] = 1'b0;
`endif

        // Model: predicts handshake signals, pushes each completed block sum
        always begin
            @(negedge clk);
            #1;
            chk($sformatf("in_ready%0d", g), 32'(in_ready_w[g]), 32'(!rst && !clr && !m_hold));
            chk($sformatf("out_valid%0d", g), 32'(out_valid_w[g]), 32'(m_hold));
            if (rst || clr) begin
                if (m_hold && q.size() > 0) void'(q.pop_back());
                m_hold = 1'b0;
                m_acc  = 0;
                m_cnt  = 0;
                m_sat  = 1'b0;
            end else if (m_hold) begin
                if (out_ready) m_hold = 1'b0;
            end else if (in_valid) begin
                m_sat = m_sat | ref_sat(m_acc, in_data);
                m_acc = ref_add(m_acc, in_data);
                m_cnt++;
                if (m_cnt == BL) begin
                    q.push_back('{data: enc(m_acc), sat: m_sat});
                    m_acc  = 0;
                    m_cnt  = 0;
                    m_sat  = 1'b0;
                    m_hold = 1'b1;
                end
            end
        end

        // Monitor: compares a presented sum against the queue head each cycle
        always begin
            @(negedge clk);
            if (out_valid_w[g] === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out%0d: got %h want none", g, out_data_w[g]);
                end else begin
                    chk($sformatf("out_data%0d", g), 32'(out_data_w[g]), 32'(q[0].data));
`ifdef SM_ACC_SAT_FLAG_EN
                    chk($sformatf("out_sat%0d", g), 32'(out_sat_w[g]), 32'(q[0].sat));
`endif
                    if (out_ready && !rst && !clr) void'(q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [11:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    task automatic do_clr();
        in_valid = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    logic [11:0] t1 [4] = '{12'h005, 12'h007, 12'h803, 12'h001};
    logic [11:0] t2 [4] = '{12'h805, 12'h005, 12'h800, 12'h000};

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_data", 32'(out_data_w[0]), 32'h0);

        // 1: mixed signs, sum visible one cycle after the last beat
        do_clr();
        for (int i = 0; i < 4; i++) beat(t1[i]);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", 32'(out_valid_w[0]), 32'h1);
        chk("t1_sum", 32'(out_data_w[0]), 32'h000A);
        step();

        // 2: cancellation and -0 inputs give +0
        do_clr();
        for (int i = 0; i < 4; i++) beat(t2[i]);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_sum", 32'(out_data_w[0]), 32'h0000);
        step();

        // 3: saturation in both directions on the 20-sample instance
        do_clr();
        for (int i = 0; i < 20; i++) beat(12'h7FF);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_pos_sat", 32'(out_data_w[1]), 32'h7FFF);
`ifdef SM_ACC_SAT_FLAG_EN
        chk("t3_pos_flag", 32'(out_sat_w[1]), 32'h1);
`endif
        step();
        for (int i = 0; i < 20; i++) beat(12'hFFF);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_neg_sat", 32'(out_data_w[1]), 32'hFFFF);
        step();

        // 4: backpressure, beats offered while the sum is held
        do_clr();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(12'($urandom));
        for (int i = 0; i < 5; i++) beat(12'h033);
        out_ready = 1'b1;
        step();
        step();
        idle();

        // 5: clr mid-block, then clr while holding
        do_clr();
        beat(12'h010);
        beat(12'h010);
        do_clr();
        for (int i = 0; i < 4; i++) beat(12'h001);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_sum", 32'(out_data_w[0]), 32'h0004);
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(12'h011);
        idle();
        do_clr();
        out_ready = 1'b1;
        idle();

        // 6: rst mid-block and in HOLD, then a clean block
        beat(12'h002);
        beat(12'h002);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_mid_data", 32'(out_data_w[0]), 32'h0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(12'h021);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_hold_data", 32'(out_data_w[0]), 32'h0);
        chk("t6_rst_hold_valid", 32'(out_valid_w[0]), 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(12'h002);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_sum", 32'(out_data_w[0]), 32'h0008);
        step();

        // Random traffic including rare clr/rst and extreme samples
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       in_data = 12'h7FF;
                1:       in_data = 12'hFFF;
                2:       in_data = 12'h800;
                default: in_data = 12'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 59) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst       = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("drain0", 32'(gen_inst[0].q.size()), 32'h0);
        chk("drain1", 32'(gen_inst[1].q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
